midi_player: RTL and testbench

- Monophonic MIDI-note synthesizer voice. Takes a MIDI note number plus a gate (midi_valid) and produces a 16-bit signed PCM stream.
- Signal chain: per-note phase accumulator (NCO), selectable waveform, ADSR envelope, amplitude scaling, one-pole low-pass filter.
- Sits between the note/controller front end and the audio output / DAC serializer.

---
 rtl/midi_player.sv | 226 ++++++++++++++++++++++
 tb/tb_midi_player.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/midi_player.sv
// midi_player: monophonic synth voice. A MIDI note drives a 32-bit NCO, the
// selected waveform is shaped by an ADSR envelope and master volume, then
// smoothed by a one-pole low-pass filter before leaving as 16-bit PCM.
module midi_player #(
    parameter int unsigned SAMPLE_DIV    = 1,
    parameter int unsigned SAMPLE_RATE   = 44100,
    parameter int unsigned ATTACK_STEP   = 148,
    parameter int unsigned DECAY_STEP    = 16,
    parameter logic [15:0] SUSTAIN_LEVEL = 16'hC000,
    parameter int unsigned RELEASE_STEP  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  midi_data,
    input  logic        midi_valid,
    input  logic [7:0]  amplitude,
    input  logic [1:0]  waveform_select,
    input  logic [7:0]  filter_alpha,
    output logic [15:0] sound_data,
    output logic        sound_valid
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_ATTACK, ST_DECAY, ST_SUSTAIN, ST_RELEASE
    } env_state_e;

    localparam logic [15:0] ATK_STEP = 16'(ATTACK_STEP);
    localparam logic [15:0] DEC_STEP = 16'(DECAY_STEP);
    localparam logic [15:0] REL_STEP = 16'(RELEASE_STEP);

    // Equal-tempered phase increment for note n, A4 (69) = 440 Hz.
    function automatic logic [31:0] note_inc(input int n);
        real freq;
        freq = 440.0 * (2.0 ** ((real'(n) - 69.0) / 12.0));
        return 32'($rtoi(4294967296.0 * freq / real'(SAMPLE_RATE) + 0.5));
    endfunction

    // NOTE: the increment table is an elaboration-time constant, so it needs
    // neither storage nor reset; it folds into plain combinational logic.
    logic [31:0] inc_rom [128];
    for (genvar g = 0; g < 128; g++) begin : g_inc_rom
        localparam logic [31:0] INC = note_inc(g);
        assign inc_rom[g] = INC;
    end

    // Bit 7 of a MIDI data byte is a status flag, meaningless for a note number.
    logic unused_midi_bit7;
    assign unused_midi_bit7 = midi_data[7];

    // Sample-rate divider, NCO, noise LFSR and gate history.
    logic [15:0] div_cnt_q;
    logic        tick;
    logic [31:0] phase_q;
    logic [15:0] lfsr_q;
    logic        gate_q;
    logic        lfsr_fb;

    assign tick    = (div_cnt_q == 16'(SAMPLE_DIV - 1));
    assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

    // Advance the divider every clk; oscillator state moves only on a tick.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset) begin
            div_cnt_q <= '0;
            phase_q   <= '0;
            lfsr_q    <= 16'hACE1;
            gate_q    <= 1'b0;
        end else begin
            div_cnt_q <= tick ? '0 : div_cnt_q + 16'd1;
            if (tick) begin
                phase_q <= phase_q + inc_rom[midi_data[6:0]];
                lfsr_q  <= {lfsr_q[14:0], lfsr_fb};
                gate_q  <= midi_valid;
            end
        end
    end

    // ADSR envelope.
    env_state_e  state_q, state_d;
    logic [15:0] env_q, env_d;
    logic        rise;

    assign rise = midi_valid & ~gate_q;

    // Envelope state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            env_q   <= '0;
        end else begin
            state_q <= state_d;
            env_q   <= env_d;
        end
    end

    // Envelope next state: gate release wins over the per-state ramp.
    always_comb begin
        // NOTE: defaults first, so no path through the case leaves a
        // variable unassigned and infers a latch.
        state_d = state_q;
        env_d   = env_q;
        if (tick) begin
            unique case (state_q)
                ST_IDLE: begin
                    env_d = '0;
                    if (rise) state_d = ST_ATTACK;
                end
                ST_ATTACK: begin
                    if (!midi_valid) begin
                        state_d = ST_RELEASE;
                    end else if (env_q >= 16'hFFFF - ATK_STEP) begin
                        env_d   = 16'hFFFF;
                        state_d = ST_DECAY;
                    end else begin
                        env_d = env_q + ATK_STEP;
                    end
                end
                ST_DECAY: begin
                    if (!midi_valid) begin
                        state_d = ST_RELEASE;
                    end else if ({1'b0, env_q} <= {1'b0, SUSTAIN_LEVEL} + {1'b0, DEC_STEP}) begin
                        env_d   = SUSTAIN_LEVEL;
                        state_d = ST_SUSTAIN;
                    end else begin
                        env_d = env_q - DEC_STEP;
                    end
                end
                ST_SUSTAIN: begin
                    if (!midi_valid) state_d = ST_RELEASE;
                end
                ST_RELEASE: begin
                    if (rise) begin
                        state_d = ST_ATTACK;
                    end else if (env_q <= REL_STEP) begin
                        env_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        env_d = env_q - REL_STEP;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Stage 1 waveform generator, from the phase before this tick's advance.
    logic signed [15:0] wave_d;
    logic        [15:0] tri_t;

    assign tri_t = phase_q[31] ? ~phase_q[30:15] : phase_q[30:15];

    // Select the raw waveform sample.
    always_comb begin
        wave_d = '0;
        unique case (waveform_select)
            2'b00:   wave_d = phase_q[31] ? 16'sh8000 : 16'sh7FFF;
            2'b01:   wave_d = phase_q[31:16] ^ 16'h8000;
            2'b10:   wave_d = tri_t ^ 16'h8000;
            default: wave_d = lfsr_q;
        endcase
    end

    // Pipeline registers: wave, gain and filter stages.
    logic               s1_valid_q, s2_valid_q, sound_valid_q;
    logic signed [15:0] wave_q, v2_q, y_q;
    logic        [15:0] env_s1_q;
    logic        [7:0]  amp_s1_q, alpha_s1_q, alpha_s2_q;
    logic signed [32:0] prod1;
    logic signed [15:0] v1;
    logic signed [24:0] prod2;
    logic signed [15:0] v2_d;
    logic signed [24:0] diff, prod3;
    logic signed [15:0] y_d;

    // Stage 2 gain: envelope then master volume, arithmetic shifts only.
    always_comb begin
        prod1 = $signed(wave_q) * $signed({1'b0, env_s1_q});
        v1    = 16'(prod1 >>> 16);
        prod2 = v1 * $signed({1'b0, amp_s1_q});
        v2_d  = 16'(prod2 >>> 8);
    end

    // Stage 3 one-pole low-pass; y stays between old y and v2, so no overflow.
    always_comb begin
        diff  = 25'(v2_q) - 25'(y_q);
        prod3 = diff * $signed({17'd0, alpha_s2_q});
        y_d   = y_q + 16'(prod3 >>> 8);
    end

    // Move samples down the three-stage pipeline on their valid strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q    <= 1'b0;
            s2_valid_q    <= 1'b0;
            sound_valid_q <= 1'b0;
            wave_q        <= '0;
            env_s1_q      <= '0;
            amp_s1_q      <= '0;
            alpha_s1_q    <= '0;
            alpha_s2_q    <= '0;
            v2_q          <= '0;
            y_q           <= '0;
        end else begin
            s1_valid_q <= tick;
            if (tick) begin
                wave_q     <= wave_d;
                env_s1_q   <= env_q;
                amp_s1_q   <= amplitude;
                alpha_s1_q <= filter_alpha;
            end
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                v2_q       <= v2_d;
                alpha_s2_q <= alpha_s1_q;
            end
            sound_valid_q <= s2_valid_q;
            if (s2_valid_q) y_q <= y_d;
        end
    end

    assign sound_data  = y_q;
    assign sound_valid = sound_valid_q;

endmodule

// File: tb/tb_midi_player.sv
// tb_midi_player: drives note/gate/control sequences, predicts every output
// sample with a per-sample reference model and checks it from a scoreboard.
module tb_midi_player;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  midi_data;
    logic        midi_valid;
    logic [7:0]  amplitude;
    logic [1:0]  waveform_select;
    logic [7:0]  filter_alpha;
    logic [15:0] sound_data;
    logic        sound_valid;

    midi_player dut (
        .clk             (clk),
        .reset           (reset),
        .midi_data       (midi_data),
        .midi_valid      (midi_valid),
        .amplitude       (amplitude),
        .waveform_select (waveform_select),
        .filter_alpha    (filter_alpha),
        .sound_data      (sound_data),
        .sound_valid     (sound_valid)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          data;
        int unsigned at;
    } exp_t;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_miss = 0;
    bit   stop   = 1'b0;

    // Reference model state.
    longint    inc_tab [128];
    bit [31:0] m_phase;
    bit [15:0] m_lfsr;
    int        m_env;
    string     m_mode;
    bit        m_gate_prev;
    int        m_y;

    task automatic check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // One sample of the voice, computed from the behavioural rules.
    task automatic model_step(input int note, input bit gate, input int amp,
                              input int sel, input int alpha);
        int  wave, v1, v2, u, fb;
        bit  rise;
        exp_t e;
        case (sel)
            0:       wave = m_phase[31] ? -32768 : 32767;
            1:       wave = int'(m_phase[31:16]) - 32768;
            2: begin
                u    = int'(m_phase[30:15]);
                wave = (m_phase[31] ? 65535 - u : u) - 32768;
            end
            default: wave = (m_lfsr >= 16'h8000) ? int'(m_lfsr) - 65536 : int'(m_lfsr);
        endcase
        v1  = int'((longint'(wave) * longint'(m_env)) >>> 16);
        v2  = int'((longint'(v1) * longint'(amp)) >>> 8);
        m_y = m_y + int'((longint'(alpha) * longint'(v2 - m_y)) >>> 8);
        e.data = m_y;
        e.at   = cyc + 3;
        sb.push_back(e);

        m_phase = m_phase + 32'(inc_tab[note]);
        fb      = m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10];
        m_lfsr  = {m_lfsr[14:0], 1'(fb)};

        rise        = gate && !m_gate_prev;
        m_gate_prev = gate;
        if (!gate && (m_mode == "attack" || m_mode == "decay" || m_mode == "sustain")) begin
            m_mode = "release";
        end else if (m_mode == "idle") begin
            m_env = 0;
            if (rise) m_mode = "attack";
        end else if (m_mode == "attack") begin
            m_env = (m_env + 148 > 65535) ? 65535 : m_env + 148;
            if (m_env == 65535) m_mode = "decay";
        end else if (m_mode == "decay") begin
            m_env = (m_env - 16 < 49152) ? 49152 : m_env - 16;
            if (m_env == 49152) m_mode = "sustain";
        end else if (m_mode == "release") begin
            if (rise) m_mode = "attack";
            else begin
                m_env = (m_env - 4 < 0) ? 0 : m_env - 4;
                if (m_env == 0) m_mode = "idle";
            end
        end
    endtask

    // Drive one tick's inputs and predict its sample.
    task automatic step(input int note, input bit gate, input int amp,
                        input int sel, input int alpha);
        @(negedge clk);
        reset           = 1'b0;
        midi_data       = {1'($urandom), 7'(note)};
        midi_valid      = gate;
        amplitude       = 8'(amp);
        waveform_select = 2'(sel);
        filter_alpha    = 8'(alpha);
        model_step(note, gate, amp, sel, alpha);
    endtask

    task automatic seg(input int n, input int note, input bit gate, input int amp,
                       input int sel, input int alpha);
        repeat (n) step(note, gate, amp, sel, alpha);
    endtask

    // Monitor: pop and compare on every strobe, flag missing or extra strobes.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && sound_valid) begin
                if (sb.size() == 0) begin
                    if (!stop) check("unexpected_strobe", longint'(sound_valid), 0);
                end else begin
                    e = sb.pop_front();
                    check("sample", longint'($signed(sound_data)), longint'(e.data));
                    check("latency", longint'(cyc), longint'(e.at));
                end
            end
            if (sb.size() > 0 && sb[0].at < cyc) begin
                e = sb.pop_front();
                check("missing_strobe", longint'(cyc), longint'(e.at));
            end
        end
    end

    initial begin
        for (int n = 0; n < 128; n++)
            inc_tab[n] = longint'(4294967296.0 * 440.0 * (2.0 ** ((real'(n) - 69.0) / 12.0)) / 44100.0);
        m_phase = '0; m_lfsr = 16'hACE1; m_env = 0; m_mode = "idle";
        m_gate_prev = 1'b0; m_y = 0;

        reset = 1'b1; midi_data = '0; midi_valid = 1'b0;
        amplitude = '0; waveform_select = '0; filter_alpha = '0;
        repeat (4) begin
            @(negedge clk);
            check("reset_data", longint'(sound_data), 0);
            check("reset_valid", longint'(sound_valid), 0);
        end

        // Gate low after reset: silence whatever the controls say.
        repeat (30) step($urandom_range(127), 1'b0, $urandom_range(255),
                         $urandom_range(3), $urandom_range(255));
        // A4 saw, full volume, open filter: attack then decay into sustain.
        seg(1500, 69, 1'b1, 255, 1, 255);
        // Legato 72 -> 74 while held.
        seg(200, 72, 1'b1, 255, 1, 255);
        seg(200, 74, 1'b1, 255, 1, 255);
        // Release from sustain all the way back to idle.
        seg(12300, 72, 1'b0, 255, 1, 255);
        // Square through a heavy filter; gate drop in attack, re-raise in release.
        seg(200, 72, 1'b1, 255, 0, 8'h07);
        seg(100, 72, 1'b0, 255, 0, 8'h07);
        seg(100, 72, 1'b1, 255, 0, 8'hF7);
        seg(500, 72, 1'b1, 255, 0, 8'hF7);
        // Zero volume forces silence; then triangle and noise.
        seg(60, 72, 1'b1, 0, 2, 255);
        seg(150, 60, 1'b1, 200, 2, 128);
        seg(150, 60, 1'b1, 200, 3, 200);
        // Random segments of all controls.
        for (int s = 0; s < 40; s++)
            seg($urandom_range(80, 10), $urandom_range(127), 1'($urandom_range(1)),
                $urandom_range(255), $urandom_range(3), $urandom_range(255));

        stop = 1'b1;
        repeat (8) @(negedge clk);
        check("drain_empty", longint'(sb.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
